tb_ctrl_periph_obi: RTL and testbench
=====================================

// Module: tb_ctrl_periph_obi
// PURPOSE
//  OBI data-bus responder for the core-verification testbench subsystem; answers core loads/stores in the
//  test-control window. Turns firmware stores into tests_passed/tests_failed/exit flags for the top-level
//  checker, streams stdout characters, and provides a cycle timer with compare interrupt.
// PARAMETERS
//  BASE_ADDR   32'h2000_0000  window base; window is 64 B, addr[31:6] must equal BASE_ADDR[31:6]
//  GNT_STALL   0              cycles data_gnt_o is held low after a new req (0 = same-cycle grant)
//  PASS_MAGIC  32'd123456789  TEST_STATUS write value meaning pass; value 1 means fail
// PORTS
//  clk_i           in   1   clock
//  rst_ni          in   1   async active-low reset
//  data_req_i      in   1   OBI request
//  data_gnt_o      out  1   OBI grant
//  data_addr_i     in   32  byte address
//  data_we_i       in   1   1 = store
//  data_be_i       in   4   byte enables
//  data_wdata_i    in   32  store data
//  data_rvalid_o   out  1   response valid, exactly 1 cycle after grant
//  data_rdata_o    out  32  load data (0 for stores)
//  data_err_o      out  1   response error (unmapped offset), qualified by rvalid
//  tests_passed_o  out  1   1-cycle pulse
//  tests_failed_o  out  1   1-cycle pulse
//  exit_valid_o    out  1   1-cycle pulse
//  exit_value_o    out  32  exit code, held until next EXIT write
//  stdout_valid_o  out  1   1-cycle pulse per printed char
//  stdout_char_o   out  8   char, valid with stdout_valid_o
//  irq_timer_o     out  1   level timer interrupt
// BEHAVIOUR
//  Reset: all outputs 0; timer cnt/cmp/en 0; FSM IDLE; stall counter 0.
//  Map (offset, word-aligned): 0x00 PRINT W, 0x04 TEST_STATUS W, 0x08 EXIT W, 0x0C TIMER_CMP RW,
//   0x10 TIMER_CNT RW, 0x14 TIMER_CTRL RW (bit0 en, bit1 irq pending, write-1-clear). Other offsets/outside
//   window: granted, rvalid with data_err_o=1, rdata 0, no side effect. Reads of W-only regs return 0.
//  FSM IDLE/STALL: GNT_STALL=0 -> gnt=req combinationally in IDLE. Else req in IDLE -> STALL, count
//   GNT_STALL cycles, then gnt=1 one cycle, back to IDLE. req drop during STALL -> IDLE, counter cleared.
//  Address/we/be/wdata sampled at req&&gnt; side effects (pulses, reg updates) appear the next cycle,
//   together with rvalid. One outstanding transaction; back-to-back grant allowed in a rvalid cycle.
//  Byte enables honoured for TIMER_CMP/CNT/CTRL; PRINT uses byte0 only (be[0]=0 -> no char);
//   TEST_STATUS/EXIT require be==4'hF, else ignored (still OK response).
//  TEST_STATUS: ==PASS_MAGIC -> passed pulse; ==1 -> failed pulse; other values ignored.
//  Timer: en=1 -> cnt+1 per cycle, wraps 32'hFFFF_FFFF->0. cnt==cmp with en=1 sets pending; irq_timer_o
//   = pending. Software write to CNT overrides increment that cycle. Pending cleared by W1C; a set and
//   clear in same cycle -> set wins.
//  Reset mid-transaction: in-flight response dropped, no rvalid after reset release.
// STRUCTURE
//  Package tb_ctrl_periph_pkg: offset localparams, PASS_MAGIC default, typedef req_s {addr,we,be,wdata}.
//  Sub-module tb_ctrl_timer (cnt, cmp, en, pending, W1C) instantiated once; decode/FSM in top.
// TESTING
//  Store 0x41 to 0x00, be=4'h1 -> next cycle stdout_valid_o=1, stdout_char_o=8'h41, rvalid, err=0.
//  Store 123456789 to 0x04 -> tests_passed_o single pulse; store 1 -> tests_failed_o; store 7 -> none.
//  Store 3 to 0x08 -> exit_valid_o pulse, exit_value_o=3 held; load 0x30 -> rvalid, err=1, rdata=0.
//  CMP=10, CTRL=1 -> irq_timer_o rises when cnt==10; write CTRL=3 -> irq low next cycle, cnt keeps running.
//  GNT_STALL=2, back-to-back stores -> gnt 2 cycles after req each time, rvalid exactly 1 cycle after gnt.
//  Assert rst_ni low in the grant cycle of a store to 0x08 -> no exit pulse, no rvalid, outputs 0.

Source files
------------

// File: rtl/tb_ctrl_periph_pkg.sv
// Shared offsets, request bundle and byte-merge helper for the test-control OBI peripheral.
package tb_ctrl_periph_pkg;

  localparam logic [5:0] OFF_PRINT  = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_EXIT   = 6'h08;
  localparam logic [5:0] OFF_CMP    = 6'h0C;
  localparam logic [5:0] OFF_CNT    = 6'h10;
  localparam logic [5:0] OFF_CTRL   = 6'h14;

  localparam logic [31:0] PASS_MAGIC_DEF = 32'd123456789;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_s;

  typedef enum logic {ST_IDLE, ST_STALL} state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/tb_ctrl_periph_obi_timer.sv
// Free-running cycle timer with compare match latching a W1C pending flag.
module tb_ctrl_timer
  import tb_ctrl_periph_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_cmp,
  input  logic        wr_cnt,
  input  logic        wr_ctrl,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic        en_o,
  output logic        pending_o
);

  logic hit;
  logic clr;

  assign hit = en_o && (cnt_o == cmp_o);
  assign clr = wr_ctrl && be[0] && wdata[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o     <= '0;
      cmp_o     <= '0;
      en_o      <= 1'b0;
      pending_o <= 1'b0;
    end else begin
      // A software write to the counter takes priority over the increment.
      if (wr_cnt)
        cnt_o <= be_merge(cnt_o, wdata, be);
      else if (en_o)
        cnt_o <= cnt_o + 32'd1;
      if (wr_cmp)
        cmp_o <= be_merge(cmp_o, wdata, be);
      if (wr_ctrl && be[0])
        en_o <= wdata[0];
      pending_o <= hit | (pending_o & ~clr);
    end
  end

endmodule

// File: rtl/tb_ctrl_periph_obi.sv
// OBI responder for the test-control window: status/exit/stdout strobes plus a compare timer.
module tb_ctrl_periph_obi
  import tb_ctrl_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int unsigned GNT_STALL  = 0,
  parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_char_o,
  output logic        irq_timer_o
);

  localparam logic [15:0] STALL_LAST = (GNT_STALL == 0) ? 16'd0 : 16'(GNT_STALL - 1);

  state_e      state, state_nxt;
  logic [15:0] stall_cnt, stall_cnt_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    case (state)
      ST_IDLE: begin
        if (data_req_i && (GNT_STALL != 0)) begin
          state_nxt     = ST_STALL;
          stall_cnt_nxt = '0;
        end
      end
      ST_STALL: begin
        if (!data_req_i || (stall_cnt == STALL_LAST)) begin
          state_nxt     = ST_IDLE;
          stall_cnt_nxt = '0;
        end else begin
          stall_cnt_nxt = stall_cnt + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    data_gnt_o = 1'b0;
    case (state)
      ST_IDLE:  data_gnt_o = data_req_i && (GNT_STALL == 0);
      ST_STALL: data_gnt_o = data_req_i && (stall_cnt == STALL_LAST);
    endcase
  end

  // ---- p0: decode of the request accepted this cycle ----
  req_s        req_p0;
  logic        acc_p0;
  logic        mapped_p0;
  logic [5:0]  off_p0;
  logic        wr_p0;
  logic        wr_print_p0, wr_status_p0, wr_exit_p0;
  logic        wr_cmp_p0, wr_cnt_p0, wr_ctrl_p0;
  logic [31:0] rdata_p0;
  logic [31:0] tmr_cnt, tmr_cmp;
  logic        tmr_en, tmr_pending;

  assign req_p0 = '{addr: data_addr_i, we: data_we_i, be: data_be_i, wdata: data_wdata_i};
  assign acc_p0 = data_req_i && data_gnt_o;
  assign off_p0 = req_p0.addr[5:0];

  always_comb begin
    mapped_p0 = 1'b0;
    if (req_p0.addr[31:6] == BASE_ADDR[31:6]) begin
      case (off_p0)
        OFF_PRINT, OFF_STATUS, OFF_EXIT, OFF_CMP, OFF_CNT, OFF_CTRL: mapped_p0 = 1'b1;
        default: mapped_p0 = 1'b0;
      endcase
    end
  end

  assign wr_p0        = acc_p0 && req_p0.we && mapped_p0;
  assign wr_print_p0  = wr_p0 && (off_p0 == OFF_PRINT) && req_p0.be[0];
  assign wr_status_p0 = wr_p0 && (off_p0 == OFF_STATUS) && (req_p0.be == 4'hF);
  assign wr_exit_p0   = wr_p0 && (off_p0 == OFF_EXIT) && (req_p0.be == 4'hF);
  assign wr_cmp_p0    = wr_p0 && (off_p0 == OFF_CMP);
  assign wr_cnt_p0    = wr_p0 && (off_p0 == OFF_CNT);
  assign wr_ctrl_p0   = wr_p0 && (off_p0 == OFF_CTRL);

  always_comb begin
    rdata_p0 = '0;
    if (acc_p0 && !req_p0.we && mapped_p0) begin
      case (off_p0)
        OFF_CMP:  rdata_p0 = tmr_cmp;
        OFF_CNT:  rdata_p0 = tmr_cnt;
        OFF_CTRL: rdata_p0 = {30'd0, tmr_pending, tmr_en};
        default:  rdata_p0 = '0;
      endcase
    end
  end

  tb_ctrl_timer u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_cmp    (wr_cmp_p0),
    .wr_cnt    (wr_cnt_p0),
    .wr_ctrl   (wr_ctrl_p0),
    .be        (req_p0.be),
    .wdata     (req_p0.wdata),
    .cnt_o     (tmr_cnt),
    .cmp_o     (tmr_cmp),
    .en_o      (tmr_en),
    .pending_o (tmr_pending)
  );

  // ---- p1: response and side-effect strobes ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_rvalid_o  <= 1'b0;
      data_rdata_o   <= '0;
      data_err_o     <= 1'b0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
      stdout_valid_o <= 1'b0;
      stdout_char_o  <= '0;
    end else begin
      data_rvalid_o  <= acc_p0;
      data_rdata_o   <= rdata_p0;
      data_err_o     <= acc_p0 && !mapped_p0;
      tests_passed_o <= wr_status_p0 && (req_p0.wdata == PASS_MAGIC);
      tests_failed_o <= wr_status_p0 && (req_p0.wdata == 32'd1);
      exit_valid_o   <= wr_exit_p0;
      stdout_valid_o <= wr_print_p0;
      if (wr_exit_p0)
        exit_value_o <= req_p0.wdata;
      if (wr_print_p0)
        stdout_char_o <= req_p0.wdata[7:0];
    end
  end

  assign irq_timer_o = tmr_pending;

endmodule

// File: tb/tb_tb_ctrl_periph_obi.sv
// Directed bench: zero-stall instance for register map/timer, two-stall instance for grant timing.
module tb_tb_ctrl_periph_obi;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        req1 = 0, we1 = 0, gnt1;
  logic [31:0] addr1 = 0, wdata1 = 0;
  logic [3:0]  be1 = 0;
  logic        rvalid1, err1, passed1, failed1, exitv1, sv1, irq1;
  logic [31:0] rdata1, exitval1;
  logic [7:0]  sc1;

  logic        req2 = 0, we2 = 0, gnt2;
  logic [31:0] addr2 = 0, wdata2 = 0;
  logic [3:0]  be2 = 0;
  logic        rvalid2, err2, passed2, failed2, exitv2, sv2, irq2;
  logic [31:0] rdata2, exitval2;
  logic [7:0]  sc2;

  tb_ctrl_periph_obi #(.BASE_ADDR(BASE), .GNT_STALL(0), .PASS_MAGIC(MAGIC)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_gnt_o(gnt1),
    .data_addr_i(addr1), .data_we_i(we1), .data_be_i(be1), .data_wdata_i(wdata1),
    .data_rvalid_o(rvalid1), .data_rdata_o(rdata1), .data_err_o(err1),
    .tests_passed_o(passed1), .tests_failed_o(failed1), .exit_valid_o(exitv1),
    .exit_value_o(exitval1), .stdout_valid_o(sv1), .stdout_char_o(sc1), .irq_timer_o(irq1)
  );

  tb_ctrl_periph_obi #(.BASE_ADDR(BASE), .GNT_STALL(2), .PASS_MAGIC(MAGIC)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req2), .data_gnt_o(gnt2),
    .data_addr_i(addr2), .data_we_i(we2), .data_be_i(be2), .data_wdata_i(wdata2),
    .data_rvalid_o(rvalid2), .data_rdata_o(rdata2), .data_err_o(err2),
    .tests_passed_o(passed2), .tests_failed_o(failed2), .exit_valid_o(exitv2),
    .exit_value_o(exitval2), .stdout_valid_o(sv2), .stdout_char_o(sc2), .irq_timer_o(irq2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns 1 time unit after the response-cycle falling edge.
  task automatic bus1(input logic we, input logic [5:0] off, input logic [31:0] wdata,
                      input logic [3:0] be);
    req1 = 1'b1; we1 = we; addr1 = BASE | {26'd0, off}; wdata1 = wdata; be1 = be;
    #1 chk("gnt_same_cycle", {31'd0, gnt1}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
    #1;
  endtask

  task automatic idle1();
    @(negedge clk);
    #1;
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", {31'd0, rvalid1}, 0);
    chk("rst_exitval", exitval1, 0);
    chk("rst_gnt", {31'd0, gnt1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_irq", {31'd0, irq1}, 0);
    chk("post_rst_stdout", {31'd0, sv1}, 0);

    bus1(1, 6'h00, 32'h0000_0041, 4'h1);
    chk("print_valid", {31'd0, sv1}, 1);
    chk("print_char", {24'd0, sc1}, 32'h41);
    chk("print_rvalid", {31'd0, rvalid1}, 1);
    chk("print_err", {31'd0, err1}, 0);
    idle1();
    chk("print_pulse_end", {31'd0, sv1}, 0);
    chk("rvalid_one_cycle", {31'd0, rvalid1}, 0);

    bus1(1, 6'h00, 32'h0000_0055, 4'h2);
    chk("print_be_no_char", {31'd0, sv1}, 0);
    chk("print_be_rvalid", {31'd0, rvalid1}, 1);

    bus1(1, 6'h04, MAGIC, 4'hF);
    chk("pass_pulse", {31'd0, passed1}, 1);
    chk("pass_no_fail", {31'd0, failed1}, 0);
    idle1();
    chk("pass_pulse_end", {31'd0, passed1}, 0);

    bus1(1, 6'h04, 32'd1, 4'hF);
    chk("fail_pulse", {31'd0, failed1}, 1);
    chk("fail_no_pass", {31'd0, passed1}, 0);

    bus1(1, 6'h04, 32'd7, 4'hF);
    chk("status7_none", {30'd0, passed1, failed1}, 0);
    chk("status7_ok", {30'd0, rvalid1, err1}, 32'b10);

    bus1(1, 6'h04, MAGIC, 4'h7);
    chk("status_partial_be", {30'd0, passed1, failed1}, 0);

    bus1(1, 6'h08, 32'd3, 4'hF);
    chk("exit_pulse", {31'd0, exitv1}, 1);
    chk("exit_value", exitval1, 3);
    idle1();
    chk("exit_pulse_end", {31'd0, exitv1}, 0);
    chk("exit_value_held", exitval1, 3);

    bus1(0, 6'h30, 32'd0, 4'hF);
    chk("unmapped_resp", {30'd0, rvalid1, err1}, 32'b11);
    chk("unmapped_rdata", rdata1, 0);

    req1 = 1'b1; addr1 = 32'h3000_0004; be1 = 4'hF;
    @(posedge clk); @(negedge clk);
    req1 = 1'b0; addr1 = '0; #1;
    chk("outside_err", {31'd0, err1}, 1);

    bus1(0, 6'h00, 32'd0, 4'hF);
    chk("read_wonly", {31'd0, err1}, 0);
    chk("read_wonly_data", rdata1, 0);

    bus1(1, 6'h0C, 32'd10, 4'hF);
    bus1(1, 6'h14, 32'd1, 4'hF);
    n = 0;
    while (!irq1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("irq_rise_cycles", n, 11);
    bus1(1, 6'h14, 32'd3, 4'hF);
    chk("irq_w1c", {31'd0, irq1}, 0);
    bus1(0, 6'h10, 32'd0, 4'hF);
    chk("cnt_running", rdata1, 12);
    bus1(0, 6'h14, 32'd0, 4'hF);
    chk("ctrl_read", rdata1, 1);

    bus1(1, 6'h0C, 32'h0000_AB00, 4'h2);
    bus1(0, 6'h0C, 32'd0, 4'hF);
    chk("cmp_byte_en", rdata1, 32'h0000_AB0A);

    bus1(1, 6'h10, 32'hFFFF_FFFF, 4'hF);
    bus1(0, 6'h10, 32'd0, 4'hF);
    chk("cnt_max", rdata1, 32'hFFFF_FFFF);
    bus1(0, 6'h10, 32'd0, 4'hF);
    chk("cnt_wrap", rdata1, 0);

    // Stalled instance: back-to-back stores with req held high.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = BASE; wdata2 = 32'h42; be2 = 4'h1;
    #1;
    n = 0;
    while (!gnt2 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("stall_first", n, 2);
    @(posedge clk); @(negedge clk); #1;
    chk("stall_rvalid_a", {31'd0, rvalid2}, 1);
    chk("stall_char_a", {24'd0, sc2}, 32'h42);
    wdata2 = 32'h43;
    chk("stall_gnt_low", {31'd0, gnt2}, 0);
    @(negedge clk); #1;
    chk("stall_rvalid_once", {31'd0, rvalid2}, 0);
    n = 1;
    while (!gnt2 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("stall_second", n, 2);
    @(posedge clk); @(negedge clk);
    req2 = 1'b0; #1;
    chk("stall_rvalid_b", {31'd0, rvalid2}, 1);
    chk("stall_char_b", {24'd0, sc2}, 32'h43);

    // Drop req mid-stall, then a fresh request restarts the full stall.
    @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    @(negedge clk); #1;
    chk("drop_no_rvalid", {31'd0, rvalid2}, 0);
    req2 = 1'b1; wdata2 = 32'h44;
    #1;
    n = 0;
    while (!gnt2 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("stall_after_drop", n, 2);
    @(posedge clk); @(negedge clk);
    req2 = 1'b0; we2 = 1'b0; #1;

    // Reset asserted in the grant cycle of an EXIT store.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = BASE | 32'h8; wdata1 = 32'd5; be1 = 4'hF;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_exitv", {31'd0, exitv1}, 0);
    chk("rst_mid_rvalid", {31'd0, rvalid1}, 0);
    chk("rst_mid_exitval", exitval1, 0);
    @(negedge clk);
    req1 = 1'b0; we1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_rel_rvalid", {31'd0, rvalid1}, 0);
    chk("rst_rel_exitv", {31'd0, exitv1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
